// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: sweeps every stuck-0/stuck-1/invert fault on the s84 product bits
// and records which ones change Y against the fault-free golden result.
module fault_campaign_ctrl #(
    parameter int SETTLE = 1,
    parameter int NLOC   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [3:0]  b_in,
    output logic [7:0]  dp_a,
    output logic [3:0]  dp_b,
    output logic        dp_op,
    output logic [3:0]  dp_f_loc,
    output logic [1:0]  dp_f_type,
    input  logic [7:0]  dp_y,
    output logic        busy,
    output logic        done,
    output logic        err_div0,
    output logic [7:0]  golden,
    output logic [4:0]  detect_count,
    output logic [23:0] detect_map
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, b_q, b_d;
    logic [2:0]  loc_q, loc_d;
    logic [1:0]  type_q, type_d;
    logic [7:0]  a_q, a_d, golden_q, golden_d;
    logic [4:0]  count_q, count_d, idx;
    logic [23:0] map_q, map_d;
    logic        err_q, err_d, last;

    assign idx  = 5'(loc_q) * 5'd3 + 5'(type_q) - 5'd1;
    assign last = (loc_q == 3'(NLOC - 1)) && (type_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            loc_q    <= '0;
            type_q   <= '0;
            golden_q <= '0;
            count_q  <= '0;
            map_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            loc_q    <= loc_d;
            type_q   <= type_d;
            golden_q <= golden_d;
            count_q  <= count_d;
            map_q    <= map_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        loc_d    = loc_q;
        type_d   = type_q;
        golden_d = golden_q;
        count_d  = count_q;
        map_d    = map_q;
        err_d    = err_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                loc_d   = '0;
                type_d  = '0;
                if (start) begin
                    a_d      = a_in;
                    b_d      = b_in;
                    golden_d = '0;
                    count_d  = '0;
                    map_d    = '0;
                    cnt_d    = '0;
                    err_d    = (a_in == 8'd0);
                    // A zero modulus aborts straight to DONE; Y is never sampled.
                    state_d  = (a_in == 8'd0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (type_q == 2'd0) begin
                    golden_d = dp_y;
                end else if (dp_y != golden_q) begin
                    map_d[idx] = 1'b1;
                    count_d    = count_q + 5'd1;
                end
                state_d = last ? DONE : APPLY;
                type_d  = last ? 2'd0 : (type_q == 2'd3 ? 2'd1 : type_q + 2'd1);
                loc_d   = last ? 3'd0 : (type_q == 2'd3 ? loc_q + 3'd1 : loc_q);
            end
            default: state_d = IDLE;
        endcase
    end

    assign dp_a         = a_q;
    assign dp_b         = b_q;
    assign dp_op        = 1'b0;
    assign dp_f_loc     = {1'b0, loc_q};
    assign dp_f_type    = type_q;
    assign busy         = (state_q == APPLY) || (state_q == SAMPLE);
    assign done         = (state_q == DONE);
    assign err_div0     = err_q;
    assign golden       = golden_q;
    assign detect_count = count_q;
    assign detect_map   = map_q;
endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb_fault_campaign_ctrl: drives campaigns against a behavioural s84 model and
// checks results through a scoreboard of expected campaign outcomes.
module tb_fault_campaign_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start1, start3;
    logic [7:0] a_in1, a_in3, dp_a1, dp_a3, y1, y3, golden1, golden3;
    logic [3:0] b_in1, b_in3, dp_b1, dp_b3, loc1, loc3;
    logic [1:0] type1, type3;
    logic op1, op3, busy1, busy3, done1, done3, err1, err3;
    logic [4:0] cnt1, cnt3;
    logic [23:0] map1, map3;

    int ncmp = 0;
    int nerr = 0;

    typedef struct packed {
        logic [7:0]  g;
        logic [4:0]  c;
        logic [23:0] m;
        logic        e;
        logic [7:0]  n;
    } exp_t;
    exp_t sb[$];
    logic [5:0] cfg_q[$];

    function automatic logic [7:0] s84(input logic [7:0] a, input logic [3:0] b,
                                       input logic [3:0] loc, input logic [1:0] ft);
        logic [7:0] p;
        p = 8'(b * b);
        case (ft)
            2'd1: p[loc[2:0]] = 1'b0;
            2'd2: p[loc[2:0]] = 1'b1;
            2'd3: p[loc[2:0]] = ~p[loc[2:0]];
            default: ;
        endcase
        return (a == 8'd0) ? 8'hFF : p % a;
    endfunction

    assign y1 = s84(dp_a1, dp_b1, loc1, type1);
    assign y3 = s84(dp_a3, dp_b3, loc3, type3);

    fault_campaign_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a_in(a_in1), .b_in(b_in1),
        .dp_a(dp_a1), .dp_b(dp_b1), .dp_op(op1), .dp_f_loc(loc1), .dp_f_type(type1),
        .dp_y(y1), .busy(busy1), .done(done1), .err_div0(err1), .golden(golden1),
        .detect_count(cnt1), .detect_map(map1));

    fault_campaign_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .a_in(a_in3), .b_in(b_in3),
        .dp_a(dp_a3), .dp_b(dp_b3), .dp_op(op3), .dp_f_loc(loc3), .dp_f_type(type3),
        .dp_y(y3), .busy(busy3), .done(done3), .err_div0(err3), .golden(golden3),
        .detect_count(cnt3), .detect_map(map3));

    task automatic run1(input logic [7:0] a, input logic [3:0] b, input exp_t e,
                        input bit noise, input bit b2b);
        exp_t x;
        int n = 0;
        int t = 0;
        sb.push_back(e);
        if (!b2b) @(negedge clk);
        a_in1 = a; b_in1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && t < 2000) begin
            if (busy1) n++;
            t++;
            if (noise) begin
                start1 = 1'($urandom % 2);
                a_in1 = 8'($urandom);
                b_in1 = 4'($urandom);
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        x = sb.pop_front();
        ncmp++;
        if (!done1) begin nerr++; $display("FAIL timeout a=%0d b=%0d: done=%b required 1", a, b, done1); end
        ncmp++;
        if (n !== int'(x.n)) begin nerr++; $display("FAIL busy_len a=%0d b=%0d: got %0d required %0d", a, b, n, x.n); end
        ncmp++;
        if (golden1 !== x.g) begin nerr++; $display("FAIL golden a=%0d b=%0d: got %0d required %0d", a, b, golden1, x.g); end
        ncmp++;
        if (cnt1 !== x.c) begin nerr++; $display("FAIL detect_count a=%0d b=%0d: got %0d required %0d", a, b, cnt1, x.c); end
        ncmp++;
        if (map1 !== x.m) begin nerr++; $display("FAIL detect_map a=%0d b=%0d: got %h required %h", a, b, map1, x.m); end
        ncmp++;
        if (err1 !== x.e) begin nerr++; $display("FAIL err_div0 a=%0d b=%0d: got %b required %b", a, b, err1, x.e); end
        ncmp++;
        if ({dp_a1, dp_b1, op1, loc1, type1, busy1} !== {a, b, 1'b0, 4'd0, 2'd0, 1'b0})
            begin nerr++; $display("FAIL done_outputs a=%0d b=%0d: got a=%0d b=%0d op=%b loc=%0d type=%0d busy=%b required a=%0d b=%0d rest 0",
                                   a, b, dp_a1, dp_b1, op1, loc1, type1, busy1, a, b); end
    endtask

    task automatic test_reset;
        reset = 1'b1; start1 = 1'b1; start3 = 1'b1;
        a_in1 = 8'd255; b_in1 = 4'd15; a_in3 = 8'd255; b_in3 = 4'd15;
        repeat (3) @(negedge clk);
        ncmp++;
        if ({dp_a1, dp_b1, op1, loc1, type1, busy1, done1, err1, golden1, cnt1, map1} !== '0)
            begin nerr++; $display("FAIL reset_dut1: busy=%b done=%b golden=%0d map=%h required all 0", busy1, done1, golden1, map1); end
        ncmp++;
        if ({dp_a3, dp_b3, op3, loc3, type3, busy3, done3, err3, golden3, cnt3, map3} !== '0)
            begin nerr++; $display("FAIL reset_dut3: busy=%b done=%b golden=%0d map=%h required all 0", busy3, done3, golden3, map3); end
        reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic test_campaigns;
        run1(8'd255, 4'd15, {8'd225, 5'd16, 24'hB6EDB5, 1'b0, 8'd50}, 1'b0, 1'b0);
        run1(8'd4, 4'd0, {8'd0, 5'd4, 24'h000036, 1'b0, 8'd50}, 1'b0, 1'b0);
        run1(8'd1, 4'd9, {8'd0, 5'd0, 24'h0, 1'b0, 8'd50}, 1'b0, 1'b0);
    endtask

    task automatic test_div0_back_to_back;
        run1(8'd0, 4'd3, {8'd0, 5'd0, 24'h0, 1'b1, 8'd0}, 1'b0, 1'b0);
        run1(8'd255, 4'd15, {8'd225, 5'd16, 24'hB6EDB5, 1'b0, 8'd50}, 1'b0, 1'b1);
        run1(8'd4, 4'd0, {8'd0, 5'd4, 24'h000036, 1'b0, 8'd50}, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        @(negedge clk);
        a_in1 = 8'd255; b_in1 = 4'd15; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (n < 20 && busy1) begin n++; @(negedge clk); end
        reset = 1'b1; start1 = 1'b1;
        @(negedge clk);
        reset = 1'b0; start1 = 1'b0;
        ncmp++;
        if ({dp_a1, dp_b1, op1, loc1, type1, busy1, done1, err1, golden1, cnt1, map1} !== '0)
            begin nerr++; $display("FAIL reset_mid: busy=%b done=%b golden=%0d cnt=%0d map=%h required all 0", busy1, done1, golden1, cnt1, map1); end
        @(negedge clk);
        ncmp++;
        if ({busy1, done1} !== 2'b00) begin nerr++; $display("FAIL reset_mid_idle: busy=%b done=%b required 0 0", busy1, done1); end
        run1(8'd255, 4'd15, {8'd225, 5'd16, 24'hB6EDB5, 1'b0, 8'd50}, 1'b1, 1'b0);
        run1(8'd4, 4'd0, {8'd0, 5'd4, 24'h000036, 1'b0, 8'd50}, 1'b1, 1'b0);
    endtask

    task automatic test_settle3;
        int n = 0;
        int t = 0;
        logic [5:0] c;
        for (int k = 0; k < 25; k++)
            repeat (4) cfg_q.push_back(k == 0 ? 6'd0 : {4'((k - 1) / 3), 2'((k - 1) % 3 + 1)});
        @(negedge clk);
        a_in3 = 8'd255; b_in3 = 4'd15; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        while (!done3 && t < 2000) begin
            t++;
            if (busy3) begin
                n++;
                c = (cfg_q.size() > 0) ? cfg_q.pop_front() : 6'h3F;
                ncmp++;
                if ({loc3, type3} !== c)
                    begin nerr++; $display("FAIL sweep_cfg cycle %0d: got loc=%0d type=%0d required loc=%0d type=%0d", n, loc3, type3, c[5:2], c[1:0]); end
            end
            @(negedge clk);
        end
        ncmp++;
        if (n !== 100 || !done3) begin nerr++; $display("FAIL settle3_busy: got %0d cycles done=%b required 100 and 1", n, done3); end
        ncmp++;
        if ({golden3, cnt3, map3, err3} !== {8'd225, 5'd16, 24'hB6EDB5, 1'b0})
            begin nerr++; $display("FAIL settle3_results: got golden=%0d cnt=%0d map=%h err=%b required 225 16 b6edb5 0", golden3, cnt3, map3, err3); end
        cfg_q.delete();
    endtask

    initial begin
        reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
        a_in1 = '0; b_in1 = '0; a_in3 = '0; b_in3 = '0;
        test_reset;
        test_campaigns;
        test_div0_back_to_back;
        test_reset_mid;
        test_settle3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/fault_campaign_ctrl.md
Name: fault_campaign_ctrl

Overview:
- Sequences a single-stuck/invert fault campaign through the s84 square-mod datapath, where Y = (B*B) % A.
- Latches one (A, B) operand pair and captures the fault-free (golden) Y.
- Then sweeps every fault location and fault type on the datapath's f_loc/f_type inputs, compares each faulty Y against golden, and records which faults are detected.
- Sits beside s84, drives its op/f_loc/f_type/A/B inputs, and reads its Y output.

Parameters:
- SETTLE, 1: cycles a fault configuration is held before Y is sampled (range 1..15).
- NLOC, 8: number of fault locations swept (product bits 0..NLOC-1); fixed at 8 for s84.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin campaign; accepted only when busy=0
- a_in  in  8  modulus operand, latched on accepted start
- b_in  in  4  base operand, latched on accepted start
- dp_a  out  8  latched A to datapath
- dp_b  out  4  latched B to datapath
- dp_op  out  1  datapath op select; always 0 (square-mod path)
- dp_f_loc  out  4  fault location to datapath; bit 3 always 0
- dp_f_type  out  2  fault type: 0 none, 1 stuck-0, 2 stuck-1, 3 invert
- dp_y  in  8  datapath Y result (combinational from dp_* inputs)
- busy  out  1  campaign in progress
- done  out  1  one-cycle pulse at campaign end
- err_div0  out  1  latched A was 0; campaign aborted
- golden  out  8  captured fault-free Y
- detect_count  out  5  number of detected faults (0..24)
- detect_map  out  24  bit loc*3+(type-1) set when fault (loc, type) is detected

Behaviour:
- Reset (any state, mid-campaign included): state IDLE; all outputs 0, including dp_* and result registers. Reset wins over a same-cycle start.
- States:
  - IDLE: wait for start.
  - APPLY: hold config, count SETTLE cycles.
  - SAMPLE: compare for one cycle.
  - DONE: one cycle.
- IDLE/DONE, start=1:
  - Latch a_in/b_in.
  - Clear detect_count, detect_map, golden, err_div0.
  - If a_in==0: err_div0<=1 and go to DONE. No sweep; counts stay 0; the datapath modulo-by-zero result is never sampled.
  - Otherwise: measurement index k<=0 (golden), go to APPLY, busy=1.
- start while busy=1 is ignored. start in the DONE cycle is accepted, so back-to-back campaigns are allowed.
- Measurement k drives dp_f_loc/dp_f_type from registers:
  - k=0: loc 0, type 0 (golden).
  - k=1..24: loc=(k-1)/3, type=((k-1)%3)+1.
  - Order: loc outer ascending, type inner ascending.
- APPLY lasts exactly SETTLE cycles, then SAMPLE for 1 cycle. dp_* stay stable through both.
- SAMPLE:
  - k=0: golden<=dp_y.
  - k>0 and dp_y!=golden: set detect_map[k-1], increment detect_count.
  - Then k<24: k+1, go to APPLY. k==24: go to DONE.
- DONE: done=1, busy=0, dp_f_type<=0, dp_f_loc<=0; next state IDLE unless start.
- Latency: start accepted at edge E → busy=1 for 25*(SETTLE+1) cycles → done high in the following cycle. SETTLE=1 gives 50 busy cycles.
- Results (golden, counts, map, err_div0) hold until the next accepted start or reset.
- detect_count never wraps; maximum 24 fits in 5 bits.

Test Plan:
- reset, SETTLE=1, start with a_in=255, b_in=15 (C=225) → busy 50 cycles, then done pulse; golden=225, detect_count=16, detect_map=24'hB6EDB5.
- start with a_in=4, b_in=0 → golden=0, detect_count=4, detect_map=24'h000036 (stuck-1 and invert detected on loc 0 and 1 only).
- start with a_in=1, b_in=9 → golden=0, detect_count=0, detect_map=0, done after 50 busy cycles.
- start with a_in=0, b_in=3 → next cycle done=1, err_div0=1, busy never asserted, counts 0; a following start with a_in=255, b_in=15 clears err_div0 and gives the first scenario's results.
- Assert reset at busy cycle 20 of a campaign → next cycle all outputs 0, state IDLE. Pulse start again → full 50-cycle campaign with correct results. start pulses during busy have no effect on timing or results.
- SETTLE=3, a_in=255, b_in=15 → busy 100 cycles; each (f_loc, f_type) held exactly 4 cycles, in order (0,0),(0,1),(0,2),(0,3),(1,1)…(7,3); same results as the first scenario.
